morse_encoder: RTL and testbench

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_pkg.sv | 16 +
 rtl/morse_encoder_unit_tick.sv | 20 ++
 rtl/morse_encoder.sv | 50 +++++
 tb/tb_morse_encoder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared state type and letter pattern/length tables for the Morse encoder
package morse_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int PAT_W = 12;
  localparam logic [7:0][PAT_W-1:0] PAT_TABLE = {
    12'b101010100000,
    12'b111011101000,
    12'b101011101000,
    12'b100000000000,
    12'b111010100000,
    12'b111010111010,
    12'b111010101000,
    12'b101110000000
  };
  localparam logic [7:0][3:0] LEN_TABLE = {4'd7, 4'd9, 4'd9, 4'd1, 4'd7, 4'd11, 4'd9, 4'd5};
endpackage

// File: rtl/morse_encoder_unit_tick.sv
// unit_tick: one-cycle pulse every UNIT enabled cycles, restarted by clear
module unit_tick #(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic ClockIn,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int UNIT = CLOCK_FREQUENCY / 2;
  localparam int CW = $clog2(UNIT) + 1;
  logic [CW-1:0] count;
  assign tick = enable && count == '0;
  always_ff @(posedge ClockIn) begin
    if (Reset) count <= '0;
    else if (clear || tick) count <= CW'(UNIT - 1);
    else if (enable) count <= count - CW'(1);
  end
endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: transmits a selected letter A-H as a Morse on/off waveform
module morse_encoder
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic       DotDashOut,
  output logic       Busy
);
  state_t state, state_next;
  logic [PAT_W-1:0] pattern;
  logic [3:0] len;
  logic tick, load, send;
  assign send = state == SEND;
  assign load = state == IDLE && Start;
  unit_tick #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY)) u_tick (
    .ClockIn(ClockIn),
    .Reset(Reset),
    .clear(load),
    .enable(send),
    .tick(tick)
  );
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state <= IDLE;
      pattern <= '0;
      len <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        pattern <= PAT_TABLE[Letter];
        len <= LEN_TABLE[Letter];
      end else if (tick) begin
        pattern <= pattern << 1;
        len <= len - 4'd1;
      end
    end
  end
  always_comb begin
    state_next = load ? SEND : (send && tick && len == 4'd1) ? IDLE : state;
  end
  always_comb begin
    DotDashOut = send & pattern[PAT_W-1];
    Busy = send;
  end
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: directed stimulus against a dot/dash timing model of the encoder
module tb_morse_encoder;
  localparam int UNIT = 2;
  logic ClockIn = 0, Reset = 1, Start = 1;
  logic [2:0] Letter = 0;
  logic DotDashOut, Busy;
  int vectors = 0, miscompares = 0;
  bit valid = 0;
  bit q[$];
  string morse [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
  int lens [8] = '{5, 9, 11, 7, 1, 9, 9, 7};

  morse_encoder #(.CLOCK_FREQUENCY(4)) dut (
    .ClockIn(ClockIn),
    .Reset(Reset),
    .Start(Start),
    .Letter(Letter),
    .DotDashOut(DotDashOut),
    .Busy(Busy)
  );

  always #5 ClockIn = ~ClockIn;

  // dot = 1 unit on, dash = 3 units on, 1 unit off between elements
  function automatic void push_letter(int l);
    for (int i = 0; i < morse[l].len(); i++) begin
      if (i > 0) repeat (UNIT) q.push_back(1'b0);
      repeat ((morse[l][i] == "-" ? 3 : 1) * UNIT) q.push_back(1'b1);
    end
  endfunction

  always @(posedge ClockIn) begin
    if (Reset) begin
      q.delete();
      valid = 1;
    end else if (q.size() != 0) void'(q.pop_front());
    else if (Start) push_letter(int'(Letter));
  end

  always @(negedge ClockIn) begin
    if (valid) begin
      bit exp_dd, exp_bz;
      exp_bz = q.size() != 0;
      exp_dd = exp_bz ? q[0] : 1'b0;
      vectors++;
      if (DotDashOut !== exp_dd || Busy !== exp_bz) begin
        miscompares++;
        $display("FAIL model t=%0t DotDashOut=%b Busy=%b expected %b %b", $time, DotDashOut, Busy, exp_dd, exp_bz);
      end
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] l, input logic [2:0] l2, input int sw, input int hold, input int n,
                      output logic [63:0] dd, output logic [63:0] bz);
    dd = '0;
    bz = '0;
    Letter = l;
    Start = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge ClockIn);
      dd = {dd[62:0], DotDashOut};
      bz = {bz[62:0], Busy};
      if (i + 1 == sw) Letter = l2;
      if (i + 1 >= hold) Start = 0;
    end
  endtask

  initial begin
    logic [63:0] dd, bz;
    int w;
    repeat (2) begin
      @(negedge ClockIn);
      check("reset_idle", {62'd0, DotDashOut, Busy}, 64'd0);
    end
    Reset = 0;
    Start = 0;
    @(negedge ClockIn);
    check("post_reset_idle", {62'd0, DotDashOut, Busy}, 64'd0);

    send(3'd4, 3'd4, 99, 1, 3, dd, bz);
    check("E_dd", dd, 64'b110);
    check("E_busy", bz, 64'b110);

    send(3'd0, 3'd0, 99, 1, 12, dd, bz);
    check("A_dd", dd, 64'b110011111100);
    check("A_busy", bz, 64'b111111111100);

    send(3'd2, 3'd7, 4, 37, 37, dd, bz);
    check("CH_dd", dd, {27'd0, 22'b1111110011001111110011, 1'b0, 14'b11001100110011});
    check("CH_busy", bz, {27'd0, {22{1'b1}}, 1'b0, {14{1'b1}}});
    @(negedge ClockIn);

    send(3'd1, 3'd1, 99, 1, 5, dd, bz);
    check("B_head_dd", dd, 64'b11111);
    check("B_head_busy", bz, 64'b11111);
    Reset = 1;
    @(negedge ClockIn);
    check("B_abort", {62'd0, DotDashOut, Busy}, 64'd0);
    Reset = 0;
    repeat (4) begin
      @(negedge ClockIn);
      check("B_no_residual", {62'd0, DotDashOut, Busy}, 64'd0);
    end

    for (int l = 0; l < 8; l++) begin
      Letter = 3'(l);
      Start = 1;
      w = 0;
      do begin
        @(negedge ClockIn);
        if (Busy) w++;
      end while (Busy && w < 100);
      check($sformatf("width_%0d", l), 64'(w), 64'(2 * lens[l]));
    end
    Start = 0;
    repeat (3) @(negedge ClockIn);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
